// File: rtl/rf_wb_arbiter_if.sv
// Bundle of execute/memory-side handshakes, register-file write port and
// decode hazard query shared by the writeback arbiter and its neighbours.
interface rf_wb_arbiter_if #(
    parameter int DATA  = 32,
    parameter int ADDR  = 5,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            alu_valid;
    logic [ADDR-1:0] alu_wa;
    logic [DATA-1:0] alu_wd;
    logic            alu_ready;

    logic            ld_issue;
    logic [ADDR-1:0] ld_issue_rd;
    logic            ld_issue_ready;

    logic            mem_valid;
    logic [ADDR-1:0] mem_wa;
    logic [DATA-1:0] mem_wd;
    logic            mem_ready;

    logic            rf_we;
    logic [ADDR-1:0] rf_wa;
    logic [DATA-1:0] rf_wd;

    logic [ADDR-1:0] chk_ra1;
    logic [ADDR-1:0] chk_ra2;
    logic            hazard;
    logic [CW-1:0]   pending_cnt;

    modport slave (
        input  alu_valid, alu_wa, alu_wd,
        output alu_ready,
        input  ld_issue, ld_issue_rd,
        output ld_issue_ready,
        input  mem_valid, mem_wa, mem_wd,
        output mem_ready,
        output rf_we, rf_wa, rf_wd,
        input  chk_ra1, chk_ra2,
        output hazard, pending_cnt
    );

    modport master (
        output alu_valid, alu_wa, alu_wd,
        input  alu_ready,
        output ld_issue, ld_issue_rd,
        input  ld_issue_ready,
        output mem_valid, mem_wa, mem_wd,
        input  mem_ready,
        input  rf_we, rf_wa, rf_wd,
        output chk_ra1, chk_ra2,
        input  hazard, pending_cnt
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: ALU writeback versus buffered load returns,
// with a per-register busy scoreboard for pending loads and WAW protection.
module rf_wb_arbiter #(
    parameter int DATA  = 32,
    parameter int ADDR  = 5,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rstn,
    rf_wb_arbiter_if.slave bus
);
    localparam int NREG = 2 ** ADDR;
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int PW   = $clog2(DEPTH);

    logic [NREG-1:1] busy_q;
    logic [NREG-1:1] busy_d;
    logic [NREG-1:0] busy_v;

    logic [ADDR-1:0] fifo_wa_q [DEPTH];
    logic [DATA-1:0] fifo_wd_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic            issue;
    logic            alu_ok;
    logic [ADDR-1:0] head_wa;
    logic [DATA-1:0] head_wd;
    logic [ADDR-1:0] sel_wa;
    logic [DATA-1:0] sel_wd;

    assign busy_v  = {busy_q, 1'b0};
    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign head_wa = fifo_wa_q[rd_ptr_q];
    assign head_wd = fifo_wd_q[rd_ptr_q];

    assign issue   = bus.ld_issue & ~busy_v[bus.ld_issue_rd];
    assign push    = bus.mem_valid & ~full;

    // Reset gating keeps the write port quiet while rstn is held low even if
    // the ALU keeps presenting a result.
    assign alu_ok  = rstn & bus.alu_valid & ~busy_v[bus.alu_wa] & ~full;
    assign pop     = ~empty & ~alu_ok;

    always_comb begin
        sel_wa = bus.alu_wa;
        sel_wd = bus.alu_wd;
        if (pop) begin
            sel_wa = head_wa;
            sel_wd = head_wd;
        end
    end

    assign bus.alu_ready      = alu_ok;
    assign bus.ld_issue_ready = ~busy_v[bus.ld_issue_rd];
    assign bus.mem_ready      = ~full;
    assign bus.rf_we          = (alu_ok | pop) & (sel_wa != '0);
    assign bus.rf_wa          = sel_wa;
    assign bus.rf_wd          = sel_wd;
    assign bus.hazard         = busy_v[bus.chk_ra1] | busy_v[bus.chk_ra2];
    assign bus.pending_cnt    = cnt_q;

    // A fresh issue is only possible on a non-busy register, so setting after
    // the drain clear never hides a genuinely pending load.
    genvar gi;
    generate
        for (gi = 1; gi < NREG; gi++) begin : g_busy
            assign busy_d[gi] = (busy_q[gi] & ~(pop & (head_wa == ADDR'(gi))))
                              | (issue & (bus.ld_issue_rd == ADDR'(gi)));

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) busy_q[gi] <= 1'b0;
                else       busy_q[gi] <= busy_d[gi];
            end
        end
    endgenerate

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_wa_q[wr_ptr_q] <= bus.mem_wa;
            fifo_wd_q[wr_ptr_q] <= bus.mem_wd;
        end
    end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Shares the single register-file write port (WE/WA/WD) between the in-order ALU writeback path and the cache/memory load-return path. Load returns are buffered in a small FIFO. A per-register busy scoreboard tracks loads that have been issued but not yet written back. Hazard indications go to the decode stage and WAW protection is applied to ALU writes. Sits between execute/memory stages and register_file.

Parameters:
DATA, 32, data width of register file
ADDR, 5, register address width (2**ADDR registers, x0 hardwired zero)
DEPTH, 4, load-return FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
alu_valid  in  1  ALU result ready for writeback
alu_wa  in  ADDR  ALU destination register
alu_wd  in  DATA  ALU result
alu_ready  out  1  ALU write accepted this cycle
ld_issue  in  1  load issued to cache, destination to be marked busy
ld_issue_rd  in  ADDR  load destination register
ld_issue_ready  out  1  load issue accepted this cycle
mem_valid  in  1  load data returned from cache
mem_wa  in  ADDR  returned load destination
mem_wd  in  DATA  returned load data
mem_ready  out  1  return accepted into FIFO
rf_we  out  1  to register_file WE
rf_wa  out  ADDR  to register_file WA
rf_wd  out  DATA  to register_file WD
chk_ra1  in  ADDR  decode source 1
chk_ra2  in  ADDR  decode source 2
hazard  out  1  a source register has a pending load
pending_cnt  out  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is asynchronous and active-low. While rstn=0: FIFO empty, all busy bits cleared, pending_cnt=0. Outputs follow from that empty state: rf_we=0, mem_ready=1, hazard=0.
- Reset mid-operation: all pending loads and buffered data are discarded with no RF write. Upstream must reissue them.
- busy[i] (i=1..2**ADDR-1) are registered. busy[0] is constant 0.
- Issue path: ld_issue_ready = ~busy[ld_issue_rd]; it is always 1 when ld_issue_rd=0.
  - Issue accepted when ld_issue & ld_issue_ready. It sets busy[rd] at the next edge, unless rd=0.
- Return path: mem_ready = (pending_cnt != DEPTH).
  - Accept when mem_valid & mem_ready: push {mem_wa, mem_wd} at the tail.
  - No combinational bypass: a return is written to the RF no earlier than the cycle after acceptance.
- Arbitration, combinational, every cycle:
  - alu_ok = alu_valid & ~busy[alu_wa] & (pending_cnt != DEPTH). busy[0] counts as 0 (WAW guard: an ALU write never overtakes an older load to the same register).
  - drain = (pending_cnt != 0) & ~alu_ok.
  - alu_ok: ALU wins. alu_ready=1, rf_wa=alu_wa, rf_wd=alu_wd.
  - drain: FIFO head wins. rf_wa=head.wa, rf_wd=head.wd, pop at edge, busy[head.wa] cleared at the same edge.
  - Otherwise: rf_we=0, alu_ready=0.
  - FIFO full forces a drain, so the ALU stalls for at most one cycle per full event.
- rf_we = (alu_ok | drain) & (selected wa != 0). Writes to x0 complete their handshake/pop but never assert rf_we.
- rf_* are combinational, so the RF write and the busy clear land on the same edge. A reader released by hazard therefore sees the loaded value.
- hazard = busy[chk_ra1] | busy[chk_ra2], combinational from registered busy bits. Index 0 is never hazardous.
- pending_cnt is updated by +push −pop. A simultaneous push and pop (non-full) leaves the count unchanged.
- FIFO pointers wrap modulo DEPTH.
- A return for a register with no busy bit set is still written. Its busy clear is a no-op.

Test Plan:
- Reset: hold rstn=0 with mem_valid=1, alu_valid=1 -> rf_we=0, pending_cnt=0, hazard=0, no FIFO push; release -> ALU write of x5=0x11 appears combinationally with rf_we=1.
- Load flow: issue rd=7 -> hazard=1 for chk_ra1=7 from next cycle; return 0xDEAD to x7 with alu_valid=0 -> rf_we=1, rf_wa=7, rf_wd=0xDEAD the following cycle, busy[7]/hazard=0 after that edge.
- Contention: alu_valid held high (distinct regs), 4 returns pushed -> ALU wins until pending_cnt=4; then mem_ready=0, alu_ready=0 one cycle, head drains, pending_cnt=3.
- WAW: issue load x9, then alu_valid with alu_wa=9 -> alu_ready=0 and the FIFO drains x9 first; next cycle the ALU write to x9 is accepted, so the final RF value is the ALU data.
- x0: issue load rd=0 (ld_issue_ready=1, no busy set); return to x0 and ALU write to x0 -> handshakes complete, rf_we stays 0.
- Reset mid-flight: 3 entries buffered, busy set on x3/x4; pulse rstn low -> pending_cnt=0, hazard=0, no RF writes for the dropped entries.
